// File: rtl/decode_stage_pkg.sv
// Shared decode/ALU definitions: opcode map, ALU function codes, CONTROL sub-codes
// and the decoded bundle that travels from decode to execute.
package decode_stage_pkg;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_ARITH_2OP = 4'h1;
  localparam logic [3:0] OP_ARITH_1OP = 4'h2;
  localparam logic [3:0] OP_MOVI      = 4'h3;
  localparam logic [3:0] OP_ADDI      = 4'h4;
  localparam logic [3:0] OP_SUBI      = 4'h5;
  localparam logic [3:0] OP_LOAD      = 4'h6;
  localparam logic [3:0] OP_STOR      = 4'h7;
  localparam logic [3:0] OP_BEQ       = 4'h8;
  localparam logic [3:0] OP_BGE       = 4'h9;
  localparam logic [3:0] OP_BLE       = 4'hA;
  localparam logic [3:0] OP_BC        = 4'hB;
  localparam logic [3:0] OP_JUMP      = 4'hC;
  localparam logic [3:0] OP_ILL0      = 4'hD;
  localparam logic [3:0] OP_ILL1      = 4'hE;
  localparam logic [3:0] OP_CONTROL   = 4'hF;

  // Two-operand ALU function field
  localparam logic [2:0] F2_ADD  = 3'd0;
  localparam logic [2:0] F2_ADC  = 3'd1;
  localparam logic [2:0] F2_SUB  = 3'd2;
  localparam logic [2:0] F2_SBB  = 3'd3;
  localparam logic [2:0] F2_AND  = 3'd4;
  localparam logic [2:0] F2_OR   = 3'd5;
  localparam logic [2:0] F2_XOR  = 3'd6;
  localparam logic [2:0] F2_NAND = 3'd7;

  // One-operand ALU function field
  localparam logic [2:0] F1_NOT = 3'd0;
  localparam logic [2:0] F1_SHL = 3'd1;
  localparam logic [2:0] F1_SHR = 3'd2;
  localparam logic [2:0] F1_ROL = 3'd3;
  localparam logic [2:0] F1_ROR = 3'd4;
  localparam logic [2:0] F1_INC = 3'd5;
  localparam logic [2:0] F1_DEC = 3'd6;
  localparam logic [2:0] F1_NEG = 3'd7;

  localparam logic [11:0] CTL_STC   = 12'h001;
  localparam logic [11:0] CTL_STB   = 12'h002;
  localparam logic [11:0] CTL_RESET = 12'hAAA;
  localparam logic [11:0] CTL_HALT  = 12'hFFF;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_GE   = 2'b10;
  localparam logic [1:0] BR_LE   = 2'b11;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic       arith_1op;
    logic       arith_2op;
    logic       addi;
    logic       subi;
    logic       load_or_store;
    logic       stc_cmd;
    logic       stb_cmd;
    logic [2:0] alu_func;
    logic [5:0] immediate;
    logic       movi;
    logic [8:0] movi_data;
    logic [2:0] rd_addr;
    logic [2:0] rs1_addr;
    logic [2:0] rs2_addr;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] branch;
    logic       bc;
    logic       jump;
  } bundle_t;

  function automatic logic is_undefined_op(input logic [3:0] op);
    return (op == OP_ILL0) || (op == OP_ILL1);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/execute/flag signals of the decode stage; slave is the decode side.
interface decode_stage_if;
  logic        instr_valid_pi;
  logic [15:0] instr_pi;
  logic        instr_ready_po;
  logic        ex_valid_po;
  logic        ex_ready_pi;
  logic        arith_1op_po;
  logic        arith_2op_po;
  logic        addi_po;
  logic        subi_po;
  logic        load_or_store_po;
  logic        stc_cmd_po;
  logic        stb_cmd_po;
  logic [2:0]  alu_func_po;
  logic [5:0]  immediate_po;
  logic        movi_po;
  logic [8:0]  movi_data_po;
  logic [2:0]  rd_addr_po;
  logic [2:0]  rs1_addr_po;
  logic [2:0]  rs2_addr_po;
  logic        reg_write_po;
  logic        mem_write_po;
  logic [1:0]  branch_po;
  logic        bc_po;
  logic        jump_po;
  logic        flag_wr_pi;
  logic        carry_in_pi;
  logic        borrow_in_pi;
  logic        carry_flag_po;
  logic        borrow_flag_po;
  logic        halted_po;
  logic        illegal_po;

  modport slave (
    input  instr_valid_pi, instr_pi, ex_ready_pi, flag_wr_pi, carry_in_pi, borrow_in_pi,
    output instr_ready_po, ex_valid_po, arith_1op_po, arith_2op_po, addi_po, subi_po,
           load_or_store_po, stc_cmd_po, stb_cmd_po, alu_func_po, immediate_po, movi_po,
           movi_data_po, rd_addr_po, rs1_addr_po, rs2_addr_po, reg_write_po, mem_write_po,
           branch_po, bc_po, jump_po, carry_flag_po, borrow_flag_po, halted_po, illegal_po
  );

  modport master (
    output instr_valid_pi, instr_pi, ex_ready_pi, flag_wr_pi, carry_in_pi, borrow_in_pi,
    input  instr_ready_po, ex_valid_po, arith_1op_po, arith_2op_po, addi_po, subi_po,
           load_or_store_po, stc_cmd_po, stb_cmd_po, alu_func_po, immediate_po, movi_po,
           movi_data_po, rd_addr_po, rs1_addr_po, rs2_addr_po, reg_write_po, mem_write_po,
           branch_po, bc_po, jump_po, carry_flag_po, borrow_flag_po, halted_po, illegal_po
  );
endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Purely combinational instruction-to-bundle decoder; HALT/RESET/undefined
// opcodes are reported on side outputs and decode to an all-zero bundle.
module instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [15:0] instr_i,
  output bundle_t     bundle_o,
  output logic        halt_o,
  output logic        reset_o,
  output logic        illegal_o
);

  logic [3:0]  opcode_s;
  logic [11:0] ctl_code_s;
  logic        uses_regs_s;

  assign opcode_s   = instr_i[15:12];
  assign ctl_code_s = instr_i[11:0];

  // Class decode; register fields only carry meaning for opcodes 0001..1100
  always_comb begin
    bundle_o    = '0;
    halt_o      = 1'b0;
    reset_o     = 1'b0;
    illegal_o   = is_undefined_op(opcode_s);
    uses_regs_s = 1'b1;
    case (opcode_s)
      OP_ARITH_2OP: begin
        bundle_o.arith_2op = 1'b1;
        bundle_o.alu_func  = instr_i[2:0];
        bundle_o.reg_write = 1'b1;
      end
      OP_ARITH_1OP: begin
        bundle_o.arith_1op = 1'b1;
        bundle_o.alu_func  = instr_i[2:0];
        bundle_o.reg_write = 1'b1;
      end
      OP_MOVI: begin
        bundle_o.movi      = 1'b1;
        bundle_o.movi_data = instr_i[8:0];
        bundle_o.reg_write = 1'b1;
      end
      OP_ADDI: begin
        bundle_o.addi      = 1'b1;
        bundle_o.immediate = instr_i[5:0];
        bundle_o.reg_write = 1'b1;
      end
      OP_SUBI: begin
        bundle_o.subi      = 1'b1;
        bundle_o.immediate = instr_i[5:0];
        bundle_o.reg_write = 1'b1;
      end
      OP_LOAD: begin
        bundle_o.load_or_store = 1'b1;
        bundle_o.immediate     = instr_i[5:0];
        bundle_o.reg_write     = 1'b1;
      end
      OP_STOR: begin
        bundle_o.load_or_store = 1'b1;
        bundle_o.immediate     = instr_i[5:0];
        bundle_o.mem_write     = 1'b1;
      end
      OP_BEQ:  bundle_o.branch = BR_EQ;
      OP_BGE:  bundle_o.branch = BR_GE;
      OP_BLE:  bundle_o.branch = BR_LE;
      OP_BC:   bundle_o.bc     = 1'b1;
      OP_JUMP: bundle_o.jump   = 1'b1;
      OP_CONTROL: begin
        uses_regs_s = 1'b0;
        case (ctl_code_s)
          CTL_STC:   bundle_o.stc_cmd = 1'b1;
          CTL_STB:   bundle_o.stb_cmd = 1'b1;
          CTL_HALT:  halt_o  = 1'b1;
          CTL_RESET: reset_o = 1'b1;
          default:   bundle_o.stc_cmd = 1'b0;
        endcase
      end
      default: uses_regs_s = 1'b0;
    endcase

    if (uses_regs_s) begin
      bundle_o.rd_addr  = instr_i[11:9];
      bundle_o.rs1_addr = instr_i[8:6];
      bundle_o.rs2_addr = instr_i[5:3];
    end else begin
      bundle_o.rd_addr  = 3'd0;
      bundle_o.rs1_addr = 3'd0;
      bundle_o.rs2_addr = 3'd0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-deep registered bundle toward execute, RUN/HALT control
// and the architectural carry/borrow flags.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic           clk_pi,
  input  logic           rst_n_pi,
  decode_stage_if.slave  bus
);

  bundle_t dec_s;
  bundle_t bundle_d;
  bundle_t bundle_q;
  logic    halt_s;
  logic    reset_s;
  logic    illegal_s;
  logic    instr_ready_s;
  logic    xfer_s;
  logic    flag_clr_s;
  logic    ex_valid_d;
  logic    ex_valid_q;
  logic    illegal_q;
  logic    halted_q;
  logic    carry_q;
  logic    borrow_q;
  state_e  state_q;

  instr_decoder u_instr_decoder (
    .instr_i   (bus.instr_pi),
    .bundle_o  (dec_s),
    .halt_o    (halt_s),
    .reset_o   (reset_s),
    .illegal_o (illegal_s)
  );

  assign instr_ready_s = (!ex_valid_q || bus.ex_ready_pi) && !halted_q;
  assign xfer_s        = bus.instr_valid_pi && instr_ready_s;
  assign flag_clr_s    = xfer_s && reset_s;

  // Load on transfer, drain to zero when consumed with nothing behind, else hold
  always_comb begin
    if (xfer_s) begin
      bundle_d   = dec_s;
      ex_valid_d = 1'b1;
    end else if (bus.ex_ready_pi) begin
      bundle_d   = '0;
      ex_valid_d = 1'b0;
    end else begin
      bundle_d   = bundle_q;
      ex_valid_d = ex_valid_q;
    end
  end

  // Pipeline register; illegal is a single-cycle pulse, not part of the held bundle
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      bundle_q   <= '0;
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      bundle_q   <= bundle_d;
      ex_valid_q <= ex_valid_d;
      illegal_q  <= xfer_s && illegal_s;
    end
  end

  // RUN/HALT state machine; HALT is left only through rst_n_pi
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (xfer_s && halt_s) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        ST_HALT: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Architectural flags; an accepted CONTROL RESET beats a same-cycle ALU commit
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else if (flag_clr_s) begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else if (bus.flag_wr_pi) begin
      carry_q  <= bus.carry_in_pi;
      borrow_q <= bus.borrow_in_pi;
    end else begin
      carry_q  <= carry_q;
      borrow_q <= borrow_q;
    end
  end

  assign bus.instr_ready_po   = instr_ready_s;
  assign bus.ex_valid_po      = ex_valid_q;
  assign bus.arith_1op_po     = bundle_q.arith_1op;
  assign bus.arith_2op_po     = bundle_q.arith_2op;
  assign bus.addi_po          = bundle_q.addi;
  assign bus.subi_po          = bundle_q.subi;
  assign bus.load_or_store_po = bundle_q.load_or_store;
  assign bus.stc_cmd_po       = bundle_q.stc_cmd;
  assign bus.stb_cmd_po       = bundle_q.stb_cmd;
  assign bus.alu_func_po      = bundle_q.alu_func;
  assign bus.immediate_po     = bundle_q.immediate;
  assign bus.movi_po          = bundle_q.movi;
  assign bus.movi_data_po     = bundle_q.movi_data;
  assign bus.rd_addr_po       = bundle_q.rd_addr;
  assign bus.rs1_addr_po      = bundle_q.rs1_addr;
  assign bus.rs2_addr_po      = bundle_q.rs2_addr;
  assign bus.reg_write_po     = bundle_q.reg_write;
  assign bus.mem_write_po     = bundle_q.mem_write;
  assign bus.branch_po        = bundle_q.branch;
  assign bus.bc_po            = bundle_q.bc;
  assign bus.jump_po          = bundle_q.jump;
  assign bus.carry_flag_po    = carry_q;
  assign bus.borrow_flag_po   = borrow_q;
  assign bus.halted_po        = halted_q;
  assign bus.illegal_po       = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of handshake, flags and HALT.
module tb_decode_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   failed;
  int   halt_cnt;

  logic [40:0] exp_q[$];
  logic [40:0] obs_s;

  logic m_valid;
  logic m_halted;
  logic m_carry;
  logic m_borrow;
  logic m_ill;
  logic m_ready;
  logic m_xfer;

  decode_stage_if bus ();

  decode_stage dut (
    .clk_pi   (clk),
    .rst_n_pi (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs_s = {bus.arith_1op_po, bus.arith_2op_po, bus.addi_po, bus.subi_po,
                  bus.load_or_store_po, bus.stc_cmd_po, bus.stb_cmd_po, bus.alu_func_po,
                  bus.immediate_po, bus.movi_po, bus.movi_data_po, bus.rd_addr_po,
                  bus.rs1_addr_po, bus.rs2_addr_po, bus.reg_write_po, bus.mem_write_po,
                  bus.branch_po, bus.bc_po, bus.jump_po};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      failed++;
      if (failed <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bundle the instruction should produce, from the opcode table
  function automatic logic [40:0] exp_bundle(input logic [15:0] ins);
    logic [3:0]  op;
    logic [3:0]  bsel;
    logic        a1, a2, ad, su, ls, stc, stb, mv, rw, mw, bc, jp;
    logic [2:0]  func, rd, rs1, rs2;
    logic [5:0]  imm;
    logic [8:0]  mvd;
    logic [1:0]  br;
    op = ins[15:12];
    {a1, a2, ad, su, ls, stc, stb, mv, rw, mw, bc, jp} = 12'd0;
    func = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0;
    imm = 6'd0; mvd = 9'd0; br = 2'd0;
    if (op == 4'd1) begin a2 = 1'b1; func = ins[2:0]; rw = 1'b1; end
    if (op == 4'd2) begin a1 = 1'b1; func = ins[2:0]; rw = 1'b1; end
    if (op == 4'd3) begin mv = 1'b1; mvd = ins[8:0]; rw = 1'b1; end
    if (op == 4'd4) begin ad = 1'b1; imm = ins[5:0]; rw = 1'b1; end
    if (op == 4'd5) begin su = 1'b1; imm = ins[5:0]; rw = 1'b1; end
    if (op == 4'd6 || op == 4'd7) begin
      ls  = 1'b1;
      imm = ins[5:0];
      rw  = (op == 4'd6);
      mw  = (op == 4'd7);
    end
    if (op >= 4'd8 && op <= 4'd10) begin
      bsel = op - 4'd7;
      br   = bsel[1:0];
    end
    if (op == 4'd11) bc = 1'b1;
    if (op == 4'd12) jp = 1'b1;
    if (ins == 16'hF001) stc = 1'b1;
    if (ins == 16'hF002) stb = 1'b1;
    if (op >= 4'd1 && op <= 4'd12) begin
      rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3];
    end
    return {a1, a2, ad, su, ls, stc, stb, func, imm, mv, mvd, rd, rs1, rs2, rw, mw, br, bc, jp};
  endfunction

  // Stimulus side: every accepted instruction queues its expected bundle
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid_pi && bus.instr_ready_po)
      exp_q.push_back(exp_bundle(bus.instr_pi));
  end

  // Monitor: compares DUT outputs with the model, then advances the model one cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", 64'({bus.ex_valid_po, obs_s, bus.halted_po, bus.illegal_po,
                                bus.carry_flag_po, bus.borrow_flag_po}), 64'd0);
      m_valid = 1'b0; m_halted = 1'b0; m_carry = 1'b0; m_borrow = 1'b0; m_ill = 1'b0;
      exp_q.delete();
    end else begin
      m_ready = (!m_valid || bus.ex_ready_pi) && !m_halted;
      chk("instr_ready", 64'(bus.instr_ready_po), 64'(m_ready));
      chk("ex_valid", 64'(bus.ex_valid_po), 64'(m_valid));
      chk("halted", 64'(bus.halted_po), 64'(m_halted));
      chk("illegal", 64'(bus.illegal_po), 64'(m_ill));
      chk("flags", 64'({bus.carry_flag_po, bus.borrow_flag_po}), 64'({m_carry, m_borrow}));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
          chk("bundle", 64'(obs_s), 64'(exp_q[0]));
          if (bus.ex_ready_pi) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_bundle", 64'(obs_s), 64'd0);
      end
      m_xfer = bus.instr_valid_pi && m_ready;
      m_ill  = m_xfer && (bus.instr_pi[15:12] == 4'hD || bus.instr_pi[15:12] == 4'hE);
      if (m_xfer && bus.instr_pi == 16'hFAAA) begin
        m_carry = 1'b0; m_borrow = 1'b0;
      end else if (bus.flag_wr_pi) begin
        m_carry = bus.carry_in_pi; m_borrow = bus.borrow_in_pi;
      end
      if (m_xfer && bus.instr_pi == 16'hFFFF) m_halted = 1'b1;
      m_valid = m_xfer ? 1'b1 : (bus.ex_ready_pi ? 1'b0 : m_valid);
    end
  end

  task automatic send(input logic [15:0] ins, input logic rdy);
    @(posedge clk); #1;
    bus.instr_valid_pi = 1'b1;
    bus.instr_pi       = ins;
    bus.ex_ready_pi    = rdy;
    @(posedge clk); #1;
    bus.instr_valid_pi = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; passed = 0; failed = 0; halt_cnt = 0;
    m_valid = 1'b0; m_halted = 1'b0; m_carry = 1'b0; m_borrow = 1'b0; m_ill = 1'b0;
    bus.instr_valid_pi = 1'b0; bus.instr_pi = 16'h0000; bus.ex_ready_pi = 1'b1;
    bus.flag_wr_pi = 1'b0; bus.carry_in_pi = 1'b0; bus.borrow_in_pi = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 64'(bus.instr_ready_po), 64'd1);

    send(16'h1A52, 1'b1);
    @(negedge clk);
    chk("arith2_fields", 64'({bus.arith_2op_po, bus.alu_func_po, bus.rd_addr_po,
                              bus.rs1_addr_po, bus.rs2_addr_po, bus.reg_write_po}),
        64'({1'b1, 3'b010, 3'd5, 3'd1, 3'd2, 1'b1}));

    send(16'h4A7F, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", 64'(bus.instr_ready_po), 64'd0);
      chk("stall_imm", 64'({bus.ex_valid_po, bus.addi_po, bus.immediate_po}),
          64'({1'b1, 1'b1, 6'h3F}));
    end
    bus.ex_ready_pi = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("drained", 64'({bus.ex_valid_po, obs_s}), 64'd0);

    @(posedge clk); #1;
    bus.flag_wr_pi = 1'b1; bus.carry_in_pi = 1'b1; bus.borrow_in_pi = 1'b0;
    @(posedge clk); #1;
    bus.flag_wr_pi = 1'b0;
    @(negedge clk);
    chk("carry_set", 64'(bus.carry_flag_po), 64'd1);
    send(16'hFAAA, 1'b1);
    @(negedge clk);
    chk("carry_cleared", 64'(bus.carry_flag_po), 64'd0);
    @(posedge clk); #1;
    bus.instr_valid_pi = 1'b1; bus.instr_pi = 16'hFAAA;
    bus.flag_wr_pi = 1'b1; bus.carry_in_pi = 1'b1; bus.borrow_in_pi = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid_pi = 1'b0; bus.flag_wr_pi = 1'b0;
    @(negedge clk);
    chk("collision_flags", 64'({bus.carry_flag_po, bus.borrow_flag_po}), 64'd0);

    send(16'hD000, 1'b1);
    @(negedge clk);
    chk("illegal_pulse", 64'({bus.illegal_po, bus.ex_valid_po, obs_s}), 64'({2'b11, 41'd0}));
    @(negedge clk);
    chk("illegal_gone", 64'(bus.illegal_po), 64'd0);

    send(16'hFFFF, 1'b1);
    @(negedge clk);
    chk("halt_bundle", 64'({bus.halted_po, bus.instr_ready_po, bus.ex_valid_po, obs_s}),
        64'({3'b101, 41'd0}));
    @(posedge clk); #1;
    bus.instr_valid_pi = 1'b1; bus.instr_pi = 16'h1A52;
    bus.flag_wr_pi = 1'b1; bus.carry_in_pi = 1'b1; bus.borrow_in_pi = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("halt_blocks", 64'({bus.halted_po, bus.instr_ready_po}), 64'(2'b10));
    end
    chk("halt_flag_update", 64'(bus.carry_flag_po), 64'd1);
    bus.instr_valid_pi = 1'b0; bus.flag_wr_pi = 1'b0;
    reset_pulse();
    @(negedge clk);
    chk("halt_exit", 64'({bus.halted_po, bus.instr_ready_po}), 64'(2'b01));

    send(16'h1A52, 1'b0);
    @(negedge clk);
    chk("stalled_before_reset", 64'(bus.ex_valid_po), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({bus.ex_valid_po, obs_s, bus.illegal_po, bus.halted_po}), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    bus.ex_ready_pi = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (halt_cnt > 4 || (i % 250) == 249) begin
        halt_cnt = 0;
        bus.instr_valid_pi = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
      end else begin
        halt_cnt = bus.halted_po ? halt_cnt + 1 : 0;
        bus.instr_valid_pi = ($urandom_range(0, 9) < 7);
        bus.ex_ready_pi    = ($urandom_range(0, 9) < 7);
        bus.flag_wr_pi     = ($urandom_range(0, 3) == 0);
        bus.carry_in_pi    = 1'($urandom_range(0, 1));
        bus.borrow_in_pi   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 11))
          0:       bus.instr_pi = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
          1:       bus.instr_pi = 16'hFAAA;
          2:       bus.instr_pi = 16'hF001;
          3:       bus.instr_pi = 16'hF002;
          4:       bus.instr_pi = {4'hD + 4'($urandom_range(0, 1)), 12'($urandom)};
          5:       bus.instr_pi = 16'h0000;
          default: bus.instr_pi = 16'($urandom);
        endcase
      end
    end
    @(posedge clk); #1;
    bus.instr_valid_pi = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
